// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between the instruction ROM and the IF/ID register.
// Fetches sequential addresses on its own, buffers {instruction, pc} pairs in a
// circular buffer and presents the oldest entry combinationally at the head.
// A taken branch flushes every buffered entry and restarts fetch at the target.
module inst_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int PC_INC = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              R,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [DATA_W-1:0] rom_instruction,
  input  logic              LE,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] Target_add,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instruction,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus_4,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  // Handshake: the head is offered whenever out_valid=1 and is consumed on a
  // rising edge where LE=1 (pop = LE & out_valid). LE is ignored while empty.
  // The producer side (the ROM) is always ready; a word is accepted when the
  // queue has room or the head leaves in the same cycle. Branch overrides both.

  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Entry storage; contents are don't-care after reset, so it has no reset.
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic head_valid;
  logic is_full;
  logic pop;
  logic push;
  logic wr_en;

  assign head_valid = (count_q != '0);
  assign is_full    = (count_q == CNT_W'(DEPTH));

  // Pop/push qualification; a flush suppresses the storage write.
  always_comb begin
    pop   = LE & head_valid;
    push  = ~is_full | pop;
    wr_en = push & ~Branch;
  end

  // Next-state for pointers, occupancy and fetch address.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (Branch) begin
      fetch_addr_d = Target_add;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (push) begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        fetch_addr_d = fetch_addr_q + ADDR_W'(PC_INC);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      fetch_addr_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Entry write: capture the ROM word together with the address it came from.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= rom_instruction;
      pc_mem_q[wr_ptr_q]    <= fetch_addr_q;
    end
  end

  // Head outputs are forced to zero while empty so a bubble reads as a NOP.
  always_comb begin
    out_valid       = head_valid;
    out_instruction = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_pc          = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    out_pc_plus_4   = out_pc + ADDR_W'(PC_INC);
  end

  assign fetch_addr = fetch_addr_q;
  assign count      = count_q;
  assign full       = is_full;
  assign empty      = ~head_valid;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the prefetch buffer.
module tb_inst_prefetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int PC_INC = 4;

  logic              clk;
  logic              R;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] rom_instruction;
  logic              LE;
  logic              Branch;
  logic [ADDR_W-1:0] Target_add;
  logic              out_valid;
  logic [DATA_W-1:0] out_instruction;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus_4;
  logic [2:0]        count;
  logic              full;
  logic              empty;

  int n_checks = 0;
  int n_errors = 0;

  // Combinational ROM filled with random words.
  logic [DATA_W-1:0] rom [256];
  assign rom_instruction = rom[fetch_addr];

  // Reference model: FIFO of (instruction, pc) plus the next fetch address.
  logic [DATA_W-1:0] mq_data[$];
  int                mq_pc[$];
  int                m_fa;

  inst_prefetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_INC(PC_INC)
  ) dut (
    .clk(clk), .R(R), .fetch_addr(fetch_addr), .rom_instruction(rom_instruction),
    .LE(LE), .Branch(Branch), .Target_add(Target_add), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4),
    .count(count), .full(full), .empty(empty)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    mq_data.delete();
    mq_pc.delete();
    m_fa = 0;
  endfunction

  // One clock edge of the prefetch buffer described in queue terms.
  function automatic void model_step(input logic le, input logic br, input logic [ADDR_W-1:0] tgt);
    bit do_pop, do_push;
    if (br) begin
      mq_data.delete();
      mq_pc.delete();
      m_fa = int'(tgt);
    end else begin
      do_pop  = le && (mq_data.size() > 0);
      do_push = (mq_data.size() < DEPTH) || do_pop;
      if (do_pop) begin
        void'(mq_data.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_data.push_back(rom[m_fa]);
        mq_pc.push_back(m_fa);
        m_fa = (m_fa + PC_INC) % 256;
      end
    end
  endfunction

  // Driver: apply inputs now, clock one edge, advance model, settle #1.
  task automatic drive_cycle(input logic le, input logic br, input logic [ADDR_W-1:0] tgt);
    LE = le;
    Branch = br;
    Target_add = tgt;
    @(posedge clk);
    model_step(le, br, tgt);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    R = 1'b0;
    LE = 1'b0;
    Branch = 1'b0;
    Target_add = '0;
    @(negedge clk);
    R = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    R = 1'b0;
    LE = 1'b0;
    Branch = 1'b0;
    Target_add = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_instruction !== 32'd0) begin n_errors++; $display("FAIL reset_instr: got %h expected 0", out_instruction); end
    n_checks++; if (out_pc !== 8'd0) begin n_errors++; $display("FAIL reset_pc: got %0d expected 0", out_pc); end
    n_checks++; if (out_pc_plus_4 !== 8'd4) begin n_errors++; $display("FAIL reset_pc4: got %0d expected 4", out_pc_plus_4); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1 0", empty, full); end
    n_checks++; if (fetch_addr !== 8'd0) begin n_errors++; $display("FAIL reset_fetch: got %0d expected 0", fetch_addr); end
    R = 1'b1;
    model_reset();
  endtask

  task automatic test_sequential();
    int pc;
    n_checks++; if (out_valid !== 1'b0 || fetch_addr !== 8'd0) begin n_errors++; $display("FAIL seq_start: got valid=%0b fetch=%0d expected 0 0", out_valid, fetch_addr); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, '0);
      pc = 4 * i;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid[%0d]: got %0b expected 1", i, out_valid); end
      n_checks++; if (out_instruction !== rom[pc] || out_pc !== pc[7:0]) begin n_errors++; $display("FAIL seq_head[%0d]: got %h@%0d expected %h@%0d", i, out_instruction, out_pc, rom[pc], pc); end
      n_checks++; if (out_pc_plus_4 !== 8'(pc + 4)) begin n_errors++; $display("FAIL seq_pc4[%0d]: got %0d expected %0d", i, out_pc_plus_4, pc + 4); end
      n_checks++; if (fetch_addr !== 8'(pc + 4)) begin n_errors++; $display("FAIL seq_fetch[%0d]: got %0d expected %0d", i, fetch_addr, pc + 4); end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0);
    n_checks++; if (count !== 3'd4 || full !== 1'b1) begin n_errors++; $display("FAIL stall_full: got count=%0d full=%0b expected 4 1", count, full); end
    n_checks++; if (fetch_addr !== 8'd16) begin n_errors++; $display("FAIL stall_fetch: got %0d expected 16", fetch_addr); end
    n_checks++; if (out_instruction !== rom[0] || out_pc !== 8'd0) begin n_errors++; $display("FAIL stall_head: got %h@%0d expected %h@0", out_instruction, out_pc, rom[0]); end
    drive_cycle(1'b0, 1'b0, '0);
    n_checks++; if (fetch_addr !== 8'd16 || out_pc !== 8'd0) begin n_errors++; $display("FAIL stall_hold: got fetch=%0d pc=%0d expected 16 0", fetch_addr, out_pc); end
    drive_cycle(1'b1, 1'b0, '0);
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL stall_pop_count: got %0d expected 4", count); end
    n_checks++; if (out_instruction !== rom[4] || out_pc !== 8'd4) begin n_errors++; $display("FAIL stall_pop_head: got %h@%0d expected %h@4", out_instruction, out_pc, rom[4]); end
    n_checks++; if (fetch_addr !== 8'd20) begin n_errors++; $display("FAIL stall_pop_fetch: got %0d expected 20", fetch_addr); end
  endtask

  task automatic test_branch_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0);
    n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    drive_cycle(1'b0, 1'b1, 8'd40);
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_empty: got count=%0d empty=%0b valid=%0b expected 0 1 0", count, empty, out_valid); end
    n_checks++; if (out_instruction !== 32'd0) begin n_errors++; $display("FAIL flush_nop: got %h expected 0", out_instruction); end
    n_checks++; if (fetch_addr !== 8'd40) begin n_errors++; $display("FAIL flush_fetch: got %0d expected 40", fetch_addr); end
    drive_cycle(1'b0, 1'b0, '0);
    n_checks++; if (out_valid !== 1'b1 || out_instruction !== rom[40] || out_pc !== 8'd40) begin n_errors++; $display("FAIL flush_head: got v=%0b %h@%0d expected v=1 %h@40", out_valid, out_instruction, out_pc, rom[40]); end
  endtask

  task automatic test_wrap();
    int pc;
    apply_reset();
    drive_cycle(1'b1, 1'b1, 8'd248);
    n_checks++; if (fetch_addr !== 8'd248) begin n_errors++; $display("FAIL wrap_target: got %0d expected 248", fetch_addr); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, '0);
      pc = (248 + 4 * i) % 256;
      n_checks++; if (out_pc !== pc[7:0] || out_instruction !== rom[pc]) begin n_errors++; $display("FAIL wrap_head[%0d]: got %h@%0d expected %h@%0d", i, out_instruction, out_pc, rom[pc], pc); end
      n_checks++; if (out_pc_plus_4 !== 8'((pc + 4) % 256)) begin n_errors++; $display("FAIL wrap_pc4[%0d]: got %0d expected %0d", i, out_pc_plus_4, (pc + 4) % 256); end
      n_checks++; if (fetch_addr !== 8'((pc + 4) % 256)) begin n_errors++; $display("FAIL wrap_fetch[%0d]: got %0d expected %0d", i, fetch_addr, (pc + 4) % 256); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, '0);
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL areset_pre_full: got %0b expected 1", full); end
    #2;
    R = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_now: got count=%0d valid=%0b expected 0 0", count, out_valid); end
    n_checks++; if (fetch_addr !== 8'd0 || out_instruction !== 32'd0) begin n_errors++; $display("FAIL areset_fetch: got fetch=%0d instr=%h expected 0 0", fetch_addr, out_instruction); end
    @(negedge clk);
    R = 1'b1;
    model_reset();
    drive_cycle(1'b1, 1'b0, '0);
    n_checks++; if (out_pc !== 8'd0 || out_instruction !== rom[0] || fetch_addr !== 8'd4) begin n_errors++; $display("FAIL areset_restart: got %h@%0d fetch=%0d expected %h@0 fetch=4", out_instruction, out_pc, fetch_addr, rom[0]); end
  endtask

  task automatic test_back_to_back_branch();
    int pc;
    apply_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, '0);
    drive_cycle(1'b1, 1'b1, 8'd20);
    n_checks++; if (out_valid !== 1'b0 || fetch_addr !== 8'd20) begin n_errors++; $display("FAIL b2b_first: got valid=%0b fetch=%0d expected 0 20", out_valid, fetch_addr); end
    drive_cycle(1'b1, 1'b1, 8'd60);
    n_checks++; if (out_valid !== 1'b0 || fetch_addr !== 8'd60) begin n_errors++; $display("FAIL b2b_second: got valid=%0b fetch=%0d expected 0 60", out_valid, fetch_addr); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, '0);
      pc = 60 + 4 * i;
      n_checks++; if (out_valid !== 1'b1 || out_pc !== pc[7:0] || out_instruction !== rom[pc]) begin n_errors++; $display("FAIL b2b_head[%0d]: got v=%0b %h@%0d expected v=1 %h@%0d", i, out_valid, out_instruction, out_pc, rom[pc], pc); end
    end
  endtask

  task automatic test_random();
    logic le, br;
    logic [ADDR_W-1:0] tgt;
    int size, e_pc;
    logic [DATA_W-1:0] e_instr;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      le  = ($urandom_range(0, 99) < 55);
      br  = ($urandom_range(0, 99) < 6);
      tgt = 8'($urandom_range(0, 255));
      drive_cycle(le, br, tgt);
      size    = mq_data.size();
      e_instr = (size > 0) ? mq_data[0] : '0;
      e_pc    = (size > 0) ? mq_pc[0] : 0;
      n_checks++; if (count !== 3'(size) || full !== (size == DEPTH) || empty !== (size == 0) || out_valid !== (size > 0)) begin n_errors++; $display("FAIL rand_occupancy[%0d]: got count=%0d full=%0b empty=%0b valid=%0b expected count=%0d", i, count, full, empty, out_valid, size); end
      n_checks++; if (out_instruction !== e_instr || out_pc !== 8'(e_pc)) begin n_errors++; $display("FAIL rand_head[%0d]: got %h@%0d expected %h@%0d", i, out_instruction, out_pc, e_instr, e_pc); end
      n_checks++; if (out_pc_plus_4 !== 8'((e_pc + PC_INC) % 256)) begin n_errors++; $display("FAIL rand_pc4[%0d]: got %0d expected %0d", i, out_pc_plus_4, (e_pc + PC_INC) % 256); end
      n_checks++; if (fetch_addr !== 8'(m_fa)) begin n_errors++; $display("FAIL rand_fetch[%0d]: got %0d expected %0d", i, fetch_addr, m_fa); end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = $urandom();
    model_reset();
    test_reset();
    test_sequential();
    test_full_stall();
    test_branch_flush();
    test_wrap();
    test_async_reset();
    test_back_to_back_branch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
